// File: rtl/led_pkg.sv
// Shared mode encoding and scan/breathe direction
// constants for the LED pattern generator.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_BINARY  = 2'd1,
    MODE_SCAN    = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/led_prescaler.sv
// Free-running prescaler; tick is registered and
// high exactly while the counter holds all-ones.
module led_prescaler #(
  parameter int DIV_BITS = 22
) (
  input  logic                clk,
  input  logic                resetn,
  output logic [DIV_BITS-1:0] cnt,
  output logic                tick
);

  localparam logic [DIV_BITS-1:0] PRE = ~DIV_BITS'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= DIV_BITS'(cnt + 1);
      tick <= (cnt == PRE);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: OFF / BINARY / SCAN / BREATHE,
// mode changes deferred to the next prescaler tick.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_LEDS   = 5,
  parameter int DIV_BITS = 22,
  parameter int PWM_BITS = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        mode_in,
  input  logic              mode_we,
  output logic [N_LEDS-1:0] led,
  output logic              tick,
  output logic [1:0]        mode
);

  localparam int PW = $clog2(N_LEDS);
  localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);

  logic [DIV_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] pwm;
  mode_e               mode_q, mode_n, pend_mode;
  logic                pend_flag;
  logic [N_LEDS-1:0]   step_q, step_n, led_n;
  logic [PW-1:0]       pos_q, pos_n;
  logic                dir_q, dir_n;
  logic [PWM_BITS-1:0] bright_q, bright_n;

  led_prescaler #(
    .DIV_BITS(DIV_BITS)
  ) u_prescaler (
    .clk   (clk),
    .resetn(resetn),
    .cnt   (cnt),
    .tick  (tick)
  );

  assign pwm  = PWM_BITS'(cnt);
  assign mode = mode_q;

  always_comb begin
    mode_n   = mode_q;
    step_n   = step_q;
    pos_n    = pos_q;
    dir_n    = dir_q;
    bright_n = bright_q;
    if (tick) begin
      if (pend_flag) begin
        mode_n   = pend_mode;
        step_n   = '0;
        pos_n    = '0;
        dir_n    = DIR_UP;
        bright_n = '0;
      end else begin
        unique case (mode_q)
          MODE_OFF: ;
          MODE_BINARY:
            step_n = N_LEDS'(step_q + 1);
          MODE_SCAN: begin
            if (dir_q == DIR_UP && pos_q == LAST) begin
              pos_n = PW'(N_LEDS - 2);
              dir_n = DIR_DN;
            end else if (dir_q == DIR_DN && pos_q == '0) begin
              pos_n = PW'(1);
              dir_n = DIR_UP;
            end else if (dir_q == DIR_UP) begin
              pos_n = PW'(pos_q + 1);
            end else begin
              pos_n = PW'(pos_q - 1);
            end
          end
          MODE_BREATHE: begin
            // ends are held one extra tick while dir turns
            if (dir_q == DIR_UP) begin
              if (bright_q == '1) dir_n = DIR_DN;
              else bright_n = PWM_BITS'(bright_q + 1);
            end else begin
              if (bright_q == '0) dir_n = DIR_UP;
              else bright_n = PWM_BITS'(bright_q - 1);
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    led_n = '0;
    unique case (mode_n)
      MODE_OFF:     led_n = '0;
      MODE_BINARY:  led_n = step_n;
      MODE_SCAN:    led_n = N_LEDS'(1) << pos_n;
      MODE_BREATHE: led_n = {N_LEDS{pwm < bright_n}};
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q    <= MODE_BINARY;
      pend_mode <= MODE_OFF;
      pend_flag <= 1'b0;
      step_q    <= '0;
      pos_q     <= '0;
      dir_q     <= DIR_UP;
      bright_q  <= '0;
      led       <= '0;
    end else begin
      mode_q   <= mode_n;
      step_q   <= step_n;
      pos_q    <= pos_n;
      dir_q    <= dir_n;
      bright_q <= bright_n;
      led      <= led_n;
      if (mode_we) begin
        pend_mode <= mode_e'(mode_in);
        pend_flag <= 1'b1;
      end else if (tick) begin
        pend_flag <= 1'b0;
      end
    end
  end

endmodule
